// File: rtl/mod_counter_nbit_if.sv
// Control and status bundle for mod_counter_nbit.
// The master side (a controller or bench) drives the controls and
// observes the registered count, terminal-count pulse and overflow flag.
interface mod_counter_nbit_if #(
    parameter int unsigned WIDTH = 4
);

    // Controls
    logic             en;
    logic             up_dn;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;

    // Status, all registered inside the counter
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en,
        output up_dn,
        output sat_mode,
        output load,
        output load_val,
        output clr_ovf,
        input  q,
        input  tc,
        input  ovf
    );

    modport slave (
        input  en,
        input  up_dn,
        input  sat_mode,
        input  load,
        input  load_val,
        input  clr_ovf,
        output q,
        output tc,
        output ovf
    );

endinterface

// File: rtl/mod_counter_nbit.sv
// Parametrised modulo up/down counter with prescaler, parallel load,
// wrap/saturate mode, terminal-count pulse and sticky overflow flag.
// All outputs come straight from registers.
module mod_counter_nbit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset,
    mod_counter_nbit_if.slave   bus
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PCNT_MAX = PW'(PRESCALE - 1);

    // Elaboration-time parameter sanity checks.
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter_nbit: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_counter_nbit: PRESCALE must be at least 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic             at_bound;
    logic             bound_evt;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_val;

    // Tick generation and boundary detection for the current direction.
    always_comb begin
        tick      = bus.en && (pcnt_q == PCNT_MAX);
        at_bound  = bus.up_dn ? (count_q == MAX_VAL) : (count_q == '0);
        bound_evt = tick && at_bound;
    end

    // Load value clamp and the value a tick would produce.
    always_comb begin
        load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        step_val     = count_q;
        if (bus.up_dn) begin
            if (count_q != MAX_VAL) begin
                step_val = count_q + WIDTH'(1);
            end else if (!bus.sat_mode) begin
                step_val = '0;
            end
        end else begin
            if (count_q != '0) begin
                step_val = count_q - WIDTH'(1);
            end else if (!bus.sat_mode) begin
                step_val = MAX_VAL;
            end
        end
    end

    // Next-state selection: load beats tick, tick beats hold.
    always_comb begin
        count_d = count_q;
        pcnt_d  = pcnt_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;

        if (bus.load) begin
            count_d = load_clamped;
            pcnt_d  = '0;
        end else begin
            if (bus.en) begin
                pcnt_d = tick ? '0 : pcnt_q + PW'(1);
            end
            if (tick) begin
                count_d = step_val;
            end
            tc_d = bound_evt;
        end

        // A boundary event on the same edge as clr_ovf leaves the flag set.
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (bound_evt && !bus.load) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            pcnt_q  <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q   = count_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;

endmodule
